// File: rtl/hazard_scheduler.sv
// ---------------------------------------------------------------------------
// hazard_scheduler
//
// Pipeline hazard unit for a five-stage in-order core with a multi-cycle
// FPU side path. It selects operand forwarding sources for the decode slot.
// It also detects two kinds of stall: a load-use stall, and a dependency
// on an FPU result that is still in flight. Finally, it kills the fetched
// instruction after a taken branch.
//
// Register indices are 6 bits wide:
//   - bit 5 selects the float file;
//   - 6'd0 is the hardwired integer zero and never creates a hazard;
//   - 6'd32 (f0) is an ordinary register.
//
// Optional feature:
//   HAZARD_PERF_EN - when defined, perf_stall counts stall cycles and
//                    saturates at all-ones. When undefined, perf_stall is
//                    tied to zero and no counter register exists.
//
// Ports:
//   clk, rst              clock; asynchronous active-high reset
//   d_valid               decode slot holds a valid instruction
//   d_rs0, d_rs1          decode source registers
//   d_use0, d_use1        decode actually reads d_rs0 / d_rs1
//   d_fpu                 decode is a multi-cycle FPU op
//   d_branch, d_taken     decode is a branch / jump; its taken result
//   e_valid, e_regwrite   execute stage valid; writes a register
//   e_memread, e_rd       execute stage is a load; its destination
//   m_regwrite, m_rd      memory stage writes a register; its destination
//   fpu_issue, fpu_lat    execute issues an FPU op to e_rd with latency
//                         1..7 (a latency of 0 is treated as 1)
//   forward0, forward1    operand source: 00 regfile, 01 E, 10 M
//   stall                 hold fetch and decode
//   flush_d               kill the fetched instruction
//   flush_e               inject a bubble into execute
//   fpu_busy, fpu_done    FPU op in flight; one-cycle completion pulse
//   perf_stall            stall-cycle counter
//
// FSM states:
//   state    | meaning
//   ---------+---------------------------------------------------------
//   IDLE     | no FPU op outstanding; fpu_issue is accepted
//   FPU_BUSY | FPU op in flight; cnt counts down the remaining cycles
// ---------------------------------------------------------------------------
module hazard_scheduler (
    input  logic        clk,
    input  logic        rst,
    input  logic        d_valid,
    input  logic [5:0]  d_rs0,
    input  logic [5:0]  d_rs1,
    input  logic        d_use0,
    input  logic        d_use1,
    input  logic        d_fpu,
    input  logic        d_branch,
    input  logic        d_taken,
    input  logic        e_valid,
    input  logic        e_regwrite,
    input  logic        e_memread,
    input  logic [5:0]  e_rd,
    input  logic        m_regwrite,
    input  logic [5:0]  m_rd,
    input  logic        fpu_issue,
    input  logic [2:0]  fpu_lat,
    output logic [1:0]  forward0,
    output logic [1:0]  forward1,
    output logic        stall,
    output logic        flush_d,
    output logic        flush_e,
    output logic        fpu_busy,
    output logic        fpu_done,
    output logic [31:0] perf_stall
);

    typedef enum logic {
        IDLE     = 1'b0,
        FPU_BUSY = 1'b1
    } state_t;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_E  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    state_t     state;
    logic [2:0] cnt;
    logic [5:0] pending_rd;

    logic       src_nz0;
    logic       src_nz1;
    logic       elig0;
    logic       elig1;
    logic       e_fwd_ok;
    logic       load_use;
    logic       fpu_hazard;
    logic [2:0] lat_eff;

    // x0 never carries a real value. Forwarding into it would be harmless,
    // but it would report a misleading source, so x0 is excluded here too.
    assign src_nz0 = (d_rs0 != 6'd0);
    assign src_nz1 = (d_rs1 != 6'd0);
    assign elig0   = d_use0 & src_nz0;
    assign elig1   = d_use1 & src_nz1;

    // A load in E has no data yet, so it cannot be a forwarding source.
    assign e_fwd_ok = e_valid & e_regwrite & ~e_memread;

    always_comb begin
        forward0 = FWD_RF;
        if (src_nz0 && e_fwd_ok && (e_rd == d_rs0)) begin
            forward0 = FWD_E;
        end else if (src_nz0 && m_regwrite && (m_rd == d_rs0)) begin
            forward0 = FWD_M;
        end
    end

    always_comb begin
        forward1 = FWD_RF;
        if (src_nz1 && e_fwd_ok && (e_rd == d_rs1)) begin
            forward1 = FWD_E;
        end else if (src_nz1 && m_regwrite && (m_rd == d_rs1)) begin
            forward1 = FWD_M;
        end
    end

    // Load-use: hold decode for one cycle. The load then sits in M and its
    // data reaches decode through the M forwarding path.
    assign load_use = d_valid & e_valid & e_memread & e_regwrite &
                      ((elig0 & (e_rd == d_rs0)) | (elig1 & (e_rd == d_rs1)));

    // FPU dependency: decode either needs the pending result or wants the
    // FPU itself. The state is forced to IDLE during reset, so this term
    // is inactive then.
    assign fpu_hazard = (state == FPU_BUSY) & d_valid &
                        (d_fpu |
                         (elig0 & (pending_rd == d_rs0)) |
                         (elig1 & (pending_rd == d_rs1)));

    assign stall   = load_use | fpu_hazard;
    assign flush_e = stall;

    // While decode is held, the branch has not really resolved yet. The
    // flush fires in the cycle the branch is allowed to proceed.
    assign flush_d = d_valid & d_branch & d_taken & ~stall;

    assign lat_eff = (fpu_lat == 3'd0) ? 3'd1 : fpu_lat;

    // fpu_done is registered. It is set on the edge that loads cnt with 1,
    // so the pulse lines up with the final cycle of FPU_BUSY.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= 3'd0;
            pending_rd <= 6'd0;
            fpu_busy   <= 1'b0;
            fpu_done   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    fpu_done <= 1'b0;
                    if (fpu_issue) begin
                        state      <= FPU_BUSY;
                        pending_rd <= e_rd;
                        cnt        <= lat_eff;
                        fpu_busy   <= 1'b1;
                        fpu_done   <= (lat_eff == 3'd1);
                    end
                end
                FPU_BUSY: begin
                    // fpu_issue is ignored here. Any further FPU op is
                    // held in decode by fpu_hazard until this one retires.
                    if (cnt == 3'd1) begin
                        state    <= IDLE;
                        cnt      <= 3'd0;
                        fpu_busy <= 1'b0;
                        fpu_done <= 1'b0;
                    end else begin
                        cnt      <= cnt - 3'd1;
                        fpu_done <= (cnt == 3'd2);
                    end
                end
                default: begin
                    state    <= IDLE;
                    fpu_busy <= 1'b0;
                    fpu_done <= 1'b0;
                end
            endcase
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] perf_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_cnt <= 32'd0;
        end else if (stall && (perf_cnt != 32'hFFFF_FFFF)) begin
            perf_cnt <= perf_cnt + 32'd1;
        end
    end

    assign perf_stall = perf_cnt;
`else
    assign perf_stall = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_scheduler.sv
module tb_hazard_scheduler;

    logic        clk;
    logic        rst;
    logic        d_valid;
    logic [5:0]  d_rs0;
    logic [5:0]  d_rs1;
    logic        d_use0;
    logic        d_use1;
    logic        d_fpu;
    logic        d_branch;
    logic        d_taken;
    logic        e_valid;
    logic        e_regwrite;
    logic        e_memread;
    logic [5:0]  e_rd;
    logic        m_regwrite;
    logic [5:0]  m_rd;
    logic        fpu_issue;
    logic [2:0]  fpu_lat;
    logic [1:0]  forward0;
    logic [1:0]  forward1;
    logic        stall;
    logic        flush_d;
    logic        flush_e;
    logic        fpu_busy;
    logic        fpu_done;
    logic [31:0] perf_stall;

    hazard_scheduler dut (
        .clk        (clk),
        .rst        (rst),
        .d_valid    (d_valid),
        .d_rs0      (d_rs0),
        .d_rs1      (d_rs1),
        .d_use0     (d_use0),
        .d_use1     (d_use1),
        .d_fpu      (d_fpu),
        .d_branch   (d_branch),
        .d_taken    (d_taken),
        .e_valid    (e_valid),
        .e_regwrite (e_regwrite),
        .e_memread  (e_memread),
        .e_rd       (e_rd),
        .m_regwrite (m_regwrite),
        .m_rd       (m_rd),
        .fpu_issue  (fpu_issue),
        .fpu_lat    (fpu_lat),
        .forward0   (forward0),
        .forward1   (forward1),
        .stall      (stall),
        .flush_d    (flush_d),
        .flush_e    (flush_e),
        .fpu_busy   (fpu_busy),
        .fpu_done   (fpu_done),
        .perf_stall (perf_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Vector layout: {forward0, forward1, stall, flush_d, flush_e,
    //                 fpu_busy, fpu_done, perf_stall}
    typedef struct {
        string       name;
        logic [40:0] v;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          perf_model = 0;
    logic [40:0] obs;

    assign obs = {forward0, forward1, stall, flush_d, flush_e, fpu_busy, fpu_done, perf_stall};

    function automatic void push(string n, logic [1:0] f0, logic [1:0] f1, logic st,
                                 logic fd, logic fe, logic b, logic d);
        exp_t e;
        e.name = n;
`ifdef HAZARD_PERF_EN
        e.v = {f0, f1, st, fd, fe, b, d, perf_model[31:0]};
`else
        e.v = {f0, f1, st, fd, fe, b, d, 32'd0};
`endif
        sb.push_back(e);
    endfunction

    task automatic idle_in();
        d_valid = 0; d_rs0 = 0; d_rs1 = 0; d_use0 = 0; d_use1 = 0;
        d_fpu = 0; d_branch = 0; d_taken = 0;
        e_valid = 0; e_regwrite = 0; e_memread = 0; e_rd = 0;
        m_regwrite = 0; m_rd = 0; fpu_issue = 0; fpu_lat = 0;
    endtask

    task automatic set_d(logic v, logic [5:0] r0, logic [5:0] r1, logic u0, logic u1);
        d_valid = v; d_rs0 = r0; d_rs1 = r1; d_use0 = u0; d_use1 = u1;
    endtask

    task automatic set_e(logic v, logic rw, logic mr, logic [5:0] rd);
        e_valid = v; e_regwrite = rw; e_memread = mr; e_rd = rd;
    endtask

    task automatic set_m(logic rw, logic [5:0] rd);
        m_regwrite = rw; m_rd = rd;
    endtask

    task automatic issue(logic [5:0] rd, logic [2:0] lat);
        fpu_issue = 1; fpu_lat = lat; set_e(1, 1, 0, rd);
    endtask

    task automatic test_reset();
        exp_t e;
        rst = 1;
        perf_model = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            idle_in();
            case (i)
                0: push("rst_idle", 2'b00, 2'b00, 0, 0, 0, 0, 0);
                1: begin
                    set_e(1, 1, 0, 6'd5); set_d(1, 6'd5, 6'd0, 1, 0);
                    push("rst_fwd_live", 2'b01, 2'b00, 0, 0, 0, 0, 0);
                end
                2: begin
                    issue(6'd40, 3'd3);
                    push("rst_issue_ignored", 2'b00, 2'b00, 0, 0, 0, 0, 0);
                end
                3: push("rst_still_idle", 2'b00, 2'b00, 0, 0, 0, 0, 0);
                default: push("post_rst_idle", 2'b00, 2'b00, 0, 0, 0, 0, 0);
            endcase
            @(negedge clk);
            e = sb.pop_front();
            n_cmp++;
            if (obs !== e.v) begin
                n_bad++;
                $display("FAIL %s: got %h required %h", e.name, obs, e.v);
            end
            if (e.v[36]) perf_model++;
            if (i == 3) rst = 0;
        end
    endtask

    task automatic test_forward();
        exp_t e;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            idle_in();
            case (i)
                0: begin
                    set_e(1, 1, 0, 6'd5); set_d(1, 6'd5, 6'd0, 1, 0);
                    push("fwd_e_addi", 2'b01, 2'b00, 0, 0, 0, 0, 0);
                end
                1: begin
                    set_m(1, 6'd9); set_d(1, 6'd0, 6'd9, 0, 1);
                    push("fwd_m", 2'b00, 2'b10, 0, 0, 0, 0, 0);
                end
                2: begin
                    set_e(1, 1, 0, 6'd5); set_m(1, 6'd5); set_d(1, 6'd5, 6'd5, 1, 1);
                    push("fwd_e_over_m", 2'b01, 2'b01, 0, 0, 0, 0, 0);
                end
                3: begin
                    set_e(0, 1, 0, 6'd12); set_m(1, 6'd12); set_d(1, 6'd12, 6'd0, 1, 0);
                    push("fwd_e_invalid", 2'b10, 2'b00, 0, 0, 0, 0, 0);
                end
                default: begin
                    set_e(1, 1, 0, 6'd33); set_d(1, 6'd32, 6'd33, 1, 1);
                    push("fwd_float_file", 2'b00, 2'b01, 0, 0, 0, 0, 0);
                end
            endcase
            @(negedge clk);
            e = sb.pop_front();
            n_cmp++;
            if (obs !== e.v) begin
                n_bad++;
                $display("FAIL %s: got %h required %h", e.name, obs, e.v);
            end
            if (e.v[36]) perf_model++;
        end
    endtask

    task automatic test_load_use();
        exp_t e;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            idle_in();
            case (i)
                0: begin
                    set_e(1, 1, 1, 6'd7); set_d(1, 6'd0, 6'd7, 0, 1);
                    push("lu_stall", 2'b00, 2'b00, 1, 0, 1, 0, 0);
                end
                1: begin
                    set_m(1, 6'd7); set_d(1, 6'd0, 6'd7, 0, 1);
                    push("lu_resolve_m", 2'b00, 2'b10, 0, 0, 0, 0, 0);
                end
                2: begin
                    set_e(1, 1, 1, 6'd7); set_d(1, 6'd0, 6'd7, 0, 0);
                    push("lu_no_use", 2'b00, 2'b00, 0, 0, 0, 0, 0);
                end
                3: begin
                    set_e(1, 1, 1, 6'd7); set_d(0, 6'd7, 6'd0, 1, 0);
                    push("lu_d_invalid", 2'b00, 2'b00, 0, 0, 0, 0, 0);
                end
                default: begin
                    set_e(1, 0, 1, 6'd7); set_d(1, 6'd7, 6'd0, 1, 0);
                    push("lu_no_regwrite", 2'b00, 2'b00, 0, 0, 0, 0, 0);
                end
            endcase
            @(negedge clk);
            e = sb.pop_front();
            n_cmp++;
            if (obs !== e.v) begin
                n_bad++;
                $display("FAIL %s: got %h required %h", e.name, obs, e.v);
            end
            if (e.v[36]) perf_model++;
        end
    endtask

    task automatic test_x0();
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            idle_in();
            case (i)
                0: begin
                    set_e(1, 1, 0, 6'd0); set_d(1, 6'd0, 6'd0, 1, 0);
                    push("x0_no_fwd", 2'b00, 2'b00, 0, 0, 0, 0, 0);
                end
                1: begin
                    set_e(1, 1, 1, 6'd0); set_d(1, 6'd0, 6'd0, 1, 0);
                    push("x0_no_lu", 2'b00, 2'b00, 0, 0, 0, 0, 0);
                end
                2: begin
                    set_e(1, 1, 0, 6'd32); set_d(1, 6'd32, 6'd0, 1, 0);
                    push("f0_fwd", 2'b01, 2'b00, 0, 0, 0, 0, 0);
                end
                default: begin
                    set_e(1, 1, 1, 6'd32); set_d(1, 6'd32, 6'd0, 1, 0);
                    push("f0_lu", 2'b00, 2'b00, 1, 0, 1, 0, 0);
                end
            endcase
            @(negedge clk);
            e = sb.pop_front();
            n_cmp++;
            if (obs !== e.v) begin
                n_bad++;
                $display("FAIL %s: got %h required %h", e.name, obs, e.v);
            end
            if (e.v[36]) perf_model++;
        end
    endtask

    task automatic test_fpu();
        exp_t e;
        for (int i = 0; i < 13; i++) begin
            @(posedge clk); #1;
            idle_in();
            case (i)
                0: begin
                    issue(6'd40, 3'd3);
                    push("fpu_issue", 2'b00, 2'b00, 0, 0, 0, 0, 0);
                end
                1: begin
                    set_d(1, 6'd40, 6'd0, 1, 0);
                    push("fpu_busy_c1", 2'b00, 2'b00, 1, 0, 1, 1, 0);
                end
                2: begin
                    set_d(1, 6'd40, 6'd0, 1, 0); issue(6'd41, 3'd7);
                    push("fpu_busy_c2", 2'b00, 2'b00, 1, 0, 1, 1, 0);
                end
                3: begin
                    set_d(1, 6'd40, 6'd0, 1, 0);
                    push("fpu_done_c3", 2'b00, 2'b00, 1, 0, 1, 1, 1);
                end
                4: begin
                    set_d(1, 6'd40, 6'd0, 1, 0);
                    push("fpu_released", 2'b00, 2'b00, 0, 0, 0, 0, 0);
                end
                5: push("fpu_reissue_ignored", 2'b00, 2'b00, 0, 0, 0, 0, 0);
                6: begin
                    issue(6'd3, 3'd0);
                    push("fpu_lat0_issue", 2'b00, 2'b00, 0, 0, 0, 0, 0);
                end
                7: begin
                    set_d(1, 6'd0, 6'd0, 0, 0); d_fpu = 1;
                    push("fpu_lat0_done", 2'b00, 2'b00, 1, 0, 1, 1, 1);
                end
                8: begin
                    set_d(1, 6'd0, 6'd0, 0, 0); d_fpu = 1;
                    push("fpu_lat0_release", 2'b00, 2'b00, 0, 0, 0, 0, 0);
                end
                9: begin
                    issue(6'd40, 3'd2);
                    push("fpu_lat2_issue", 2'b00, 2'b00, 0, 0, 0, 0, 0);
                end
                10: begin
                    set_d(1, 6'd0, 6'd41, 0, 1);
                    push("fpu_indep_src", 2'b00, 2'b00, 0, 0, 0, 1, 0);
                end
                11: begin
                    set_d(1, 6'd40, 6'd41, 0, 1);
                    push("fpu_unused_src", 2'b00, 2'b00, 0, 0, 0, 1, 1);
                end
                default: push("fpu_lat2_idle", 2'b00, 2'b00, 0, 0, 0, 0, 0);
            endcase
            @(negedge clk);
            e = sb.pop_front();
            n_cmp++;
            if (obs !== e.v) begin
                n_bad++;
                $display("FAIL %s: got %h required %h", e.name, obs, e.v);
            end
            if (e.v[36]) perf_model++;
        end
    endtask

    task automatic test_branch();
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            idle_in();
            case (i)
                0: begin
                    set_e(1, 1, 1, 6'd7); set_d(1, 6'd0, 6'd7, 0, 1);
                    d_branch = 1; d_taken = 1;
                    push("br_suppressed", 2'b00, 2'b00, 1, 0, 1, 0, 0);
                end
                1: begin
                    set_m(1, 6'd7); set_d(1, 6'd0, 6'd7, 0, 1);
                    d_branch = 1; d_taken = 1;
                    push("br_flush", 2'b00, 2'b10, 0, 1, 0, 0, 0);
                end
                2: begin
                    set_d(1, 6'd0, 6'd0, 0, 0); d_branch = 1; d_taken = 0;
                    push("br_not_taken", 2'b00, 2'b00, 0, 0, 0, 0, 0);
                end
                default: begin
                    set_d(0, 6'd0, 6'd0, 0, 0); d_branch = 1; d_taken = 1;
                    push("br_d_invalid", 2'b00, 2'b00, 0, 0, 0, 0, 0);
                end
            endcase
            @(negedge clk);
            e = sb.pop_front();
            n_cmp++;
            if (obs !== e.v) begin
                n_bad++;
                $display("FAIL %s: got %h required %h", e.name, obs, e.v);
            end
            if (e.v[36]) perf_model++;
        end
    endtask

    task automatic test_combined();
        exp_t e;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            idle_in();
            case (i)
                0: begin
                    issue(6'd40, 3'd2);
                    push("comb_issue", 2'b00, 2'b00, 0, 0, 0, 0, 0);
                end
                1: begin
                    set_e(1, 1, 1, 6'd7); set_d(1, 6'd40, 6'd7, 1, 1);
                    push("comb_both", 2'b00, 2'b00, 1, 0, 1, 1, 0);
                end
                2: begin
                    set_m(1, 6'd7); set_d(1, 6'd40, 6'd7, 1, 1);
                    push("comb_fpu_only", 2'b00, 2'b10, 1, 0, 1, 1, 1);
                end
                3: begin
                    set_m(1, 6'd7); set_d(1, 6'd40, 6'd7, 1, 1);
                    push("comb_clear", 2'b00, 2'b10, 0, 0, 0, 0, 0);
                end
                default: begin
                    set_e(1, 1, 1, 6'd7); set_d(1, 6'd40, 6'd7, 1, 1);
                    push("comb_lu_only", 2'b00, 2'b00, 1, 0, 1, 0, 0);
                end
            endcase
            @(negedge clk);
            e = sb.pop_front();
            n_cmp++;
            if (obs !== e.v) begin
                n_bad++;
                $display("FAIL %s: got %h required %h", e.name, obs, e.v);
            end
            if (e.v[36]) perf_model++;
        end
    endtask

    task automatic test_perf_reset();
        exp_t e;
        for (int i = 0; i < 19; i++) begin
            @(posedge clk); #1;
            idle_in();
            if (i == 0 || i == 10) begin
                rst = 1;
                perf_model = 0;
            end
            case (i)
                0: push("pr_reset", 2'b00, 2'b00, 0, 0, 0, 0, 0);
                1, 2, 3, 4, 5: begin
                    set_e(1, 1, 1, 6'd7); set_d(1, 6'd0, 6'd7, 0, 1);
                    push($sformatf("pr_stall%0d", i), 2'b00, 2'b00, 1, 0, 1, 0, 0);
                end
                6: push("pr_count5", 2'b00, 2'b00, 0, 0, 0, 0, 0);
                7: begin
                    issue(6'd40, 3'd7);
                    push("pr_issue7", 2'b00, 2'b00, 0, 0, 0, 0, 0);
                end
                8, 9: push($sformatf("pr_busy%0d", i), 2'b00, 2'b00, 0, 0, 0, 1, 0);
                10: push("pr_mid_rst", 2'b00, 2'b00, 0, 0, 0, 0, 0);
                11: begin
                    set_d(1, 6'd40, 6'd0, 1, 0);
                    push("pr_pending_cleared", 2'b00, 2'b00, 0, 0, 0, 0, 0);
                end
                default: push($sformatf("pr_no_done%0d", i), 2'b00, 2'b00, 0, 0, 0, 0, 0);
            endcase
            @(negedge clk);
            e = sb.pop_front();
            n_cmp++;
            if (obs !== e.v) begin
                n_bad++;
                $display("FAIL %s: got %h required %h", e.name, obs, e.v);
            end
            if (e.v[36]) perf_model++;
            if (i == 0 || i == 10) rst = 0;
        end
    endtask

    initial begin
        rst = 1;
        idle_in();
        test_reset();
        test_forward();
        test_load_use();
        test_x0();
        test_fpu();
        test_branch();
        test_combined();
        test_perf_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
        $fatal(1);
    end

endmodule
